muldiv_ctrl: RTL and testbench
==============================

Name: muldiv_ctrl

Overview:
- Multi-cycle sequencer for MIPS MULT/MULTU/DIV/DIVU and MTHI/MTLO.
- Owns the HI and LO architectural registers as two gen_register instances and drives their write enables.
- Runs an iterative 1-bit-per-cycle shift-add multiply or restoring divide.
- Exposes `busy` so the hazard logic stalls MFHI/MFLO and any new mult/div until results are committed.

Parameters:
- WORD_SIZE, 32, operand width and HI/LO width; must be ≥ 2.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WORD_SIZE.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request to begin an operation; sampled only in IDLE.
- op  input  2  operation: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- rs_val  input  WORD_SIZE  multiplicand / dividend.
- rt_val  input  WORD_SIZE  multiplier / divisor.
- mthi  input  1  write rs_val into HI.
- mtlo  input  1  write rs_val into LO.
- busy  output  1  high while an operation is in flight (RUN or FIX).
- done  output  1  one-cycle pulse; HI/LO hold the new result.
- hi_out  output  WORD_SIZE  HI register contents.
- lo_out  output  WORD_SIZE  LO register contents.

Behaviour:
- Reset values:
  - Asynchronous rst forces state=IDLE, count=0, busy=0, done=0, hi_out=0, lo_out=0.
  - All internal accumulators are cleared.
  - Reset mid-operation aborts the operation with no partial HI/LO write.
- States:
  - IDLE: start=1 at edge E0 latches |operands| (magnitudes for signed ops), sign flags and op; next state RUN, count=0, busy=1.
  - RUN: one iteration per clock; count increments. After WORD_SIZE iterations (edge E0+WORD_SIZE) the next state is FIX.
  - FIX: applies sign correction, asserts the HI/LO write enables for one cycle. At edge E0+WORD_SIZE+1: HI/LO updated, done=1, busy=0, state IDLE.
- Latency: done and valid hi_out/lo_out appear WORD_SIZE+1 clocks after the start edge (33 for the default). done drops on the following edge.
- Multiply: 2·WORD_SIZE-bit product; HI=upper half, LO=lower half. MULT negates the product iff operand signs differ.
- Divide results:
  - LO=quotient, HI=remainder.
  - DIV: quotient negated iff signs differ; remainder takes the dividend's sign.
- Divide by zero (rt_val=0) completes with normal latency:
  - LO=all ones.
  - HI=rs_val unchanged.
- DIV overflow (-2^(W-1) / -1): LO=0x80000000, HI=0.
- MTHI/MTLO:
  - Honoured only in IDLE; write rs_val on the next edge; done stays 0.
  - mthi and mtlo together write both registers.
  - Ignored while busy (hazard logic guarantees they are not issued).
- start while busy: ignored; the operation in flight is undisturbed.
- start together with mthi/mtlo in IDLE: start wins; the move is dropped.
- Unlisted op values cannot occur (2-bit field fully decoded).

Decomposition:
- muldiv_pkg holds:
  - op encodings (OP_MULTU..OP_DIV);
  - state enum (IDLE, RUN, FIX);
  - the divide-by-zero and overflow result constants.
- HI and LO are two gen_register instances (WORD_SIZE parameter passed through), with write_en driven from FIX or an IDLE move.
- Iteration arithmetic stays inline in this module; no further sub-module.

Test Plan:
- MULTU 7×6, start at E0 → done only at E33; HI=0x00000000, LO=0x0000002A; busy high for exactly 33 cycles.
- MULT -3×5 → HI=0xFFFFFFFF, LO=0xFFFFFFF1. Then DIVU 100/7 → LO=0x0000000E, HI=0x00000002.
- DIV -7/2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV 0x80000000/-1 → LO=0x80000000, HI=0.
- DIVU 0x12345678/0 → LO=0xFFFFFFFF, HI=0x12345678, done at E33.
- MULTU 3×4 with a second start (op=DIV, different operands) at E10 → result is still HI=0, LO=12 at E33; no second done.
- Start MULT, assert rst at E15 → busy=0, done=0, HI=LO=0 immediately; no write at E33. Then mthi with rs_val=0xDEADBEEF in IDLE → HI=0xDEADBEEF next edge, done=0.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared encodings and fixed results for the MIPS multiply/divide sequencer.
// The result constants are MAX_WORD wide and get narrowed to the instance width.
package muldiv_pkg;

    typedef enum logic [1:0] {
        OP_MULTU = 2'b00,
        OP_MULT  = 2'b01,
        OP_DIVU  = 2'b10,
        OP_DIV   = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX
    } state_e;

    localparam int MAX_WORD = 64;

    // Divide by zero: the quotient is all ones and HI keeps the dividend.
    localparam logic [MAX_WORD-1:0] DIV0_QUOT = '1;
    // Signed overflow (most negative / -1): the remainder is zero.
    localparam logic [MAX_WORD-1:0] OVF_REM   = '0;

    // Signed overflow quotient: the most negative value of a w-bit word.
    function automatic logic [MAX_WORD-1:0] ovf_quot(input int w);
        return 64'd1 << (w - 1);
    endfunction

endpackage

// File: rtl/gen_register.sv
// Generic clearable register with a write enable; holds one of HI or LO.
module gen_register #(
    parameter int WORD_SIZE = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 write_en,
    input  logic [WORD_SIZE-1:0] d,
    output logic [WORD_SIZE-1:0] q
);

    // NOTE: non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            q <= '0;
        else if (write_en)
            q <= d;
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// Sequencer for MULT/MULTU/DIV/DIVU (one bit per clock) and MTHI/MTLO.
// Operands are reduced to magnitudes on entry; signs are reapplied in FIX.
module muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int WORD_SIZE = 32,
    parameter int CNT_W     = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [1:0]           op,
    input  logic [WORD_SIZE-1:0] rs_val,
    input  logic [WORD_SIZE-1:0] rt_val,
    input  logic                 mthi,
    input  logic                 mtlo,
    output logic                 busy,
    output logic                 done,
    output logic [WORD_SIZE-1:0] hi_out,
    output logic [WORD_SIZE-1:0] lo_out
);

    localparam logic [WORD_SIZE-1:0] MOST_NEG = {1'b1, {(WORD_SIZE-1){1'b0}}};

    state_e               state, state_nx;
    logic [CNT_W-1:0]     count;
    op_e                  op_q;
    logic [WORD_SIZE-1:0] opa;      // multiplicand or divisor magnitude
    logic [WORD_SIZE-1:0] acc_a;    // product high half or partial remainder
    logic [WORD_SIZE-1:0] acc_b;    // multiplier / product low half or quotient
    logic                 neg_res, neg_rem, div_zero, div_ovf;

    op_e                  op_in;
    logic                 in_signed, in_div, rs_neg, rt_neg;
    logic [WORD_SIZE-1:0] rs_mag, rt_mag;
    logic                 div_q, last_iter;

    logic [WORD_SIZE:0]     mul_sum, div_shift;
    logic [WORD_SIZE-1:0]   mul_a, mul_b, div_a, div_b, div_diff;
    logic                   div_ge;
    logic [2*WORD_SIZE-1:0] prod, prod_fix;
    logic [WORD_SIZE-1:0]   quot_fix, rem_fix, hi_res, lo_res;
    logic                   fix, move_ok, hi_we, lo_we;
    logic [WORD_SIZE-1:0]   hi_d, lo_d;

    assign op_in     = op_e'(op);
    assign in_signed = (op_in == OP_MULT) || (op_in == OP_DIV);
    assign in_div    = (op_in == OP_DIVU) || (op_in == OP_DIV);
    assign rs_neg    = in_signed && rs_val[WORD_SIZE-1];
    assign rt_neg    = in_signed && rt_val[WORD_SIZE-1];
    assign rs_mag    = rs_neg ? -rs_val : rs_val;
    assign rt_mag    = rt_neg ? -rt_val : rt_val;

    assign div_q     = (op_q == OP_DIVU) || (op_q == OP_DIV);
    assign last_iter = (count == CNT_W'(WORD_SIZE - 1));
    assign busy      = (state == RUN) || (state == FIX);

    // One shift-add or restoring-subtract step per clock.
    assign mul_sum   = {1'b0, acc_a} + (acc_b[0] ? {1'b0, opa} : '0);
    assign mul_a     = mul_sum[WORD_SIZE:1];
    assign mul_b     = {mul_sum[0], acc_b[WORD_SIZE-1:1]};
    assign div_shift = {acc_a, acc_b[WORD_SIZE-1]};
    assign div_ge    = (div_shift >= {1'b0, opa});
    assign div_diff  = div_shift[WORD_SIZE-1:0] - opa;
    assign div_a     = div_ge ? div_diff : div_shift[WORD_SIZE-1:0];
    assign div_b     = {acc_b[WORD_SIZE-2:0], div_ge};

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        // NOTE: defaults first so no path through the case leaves a latch.
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (last_iter) state_nx = FIX;
            FIX:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count    <= '0;
            op_q     <= OP_MULTU;
            opa      <= '0;
            acc_a    <= '0;
            acc_b    <= '0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            div_zero <= 1'b0;
            div_ovf  <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= (state == FIX);
            case (state)
                IDLE: if (start) begin
                    count    <= '0;
                    op_q     <= op_in;
                    opa      <= in_div ? rt_mag : rs_mag;
                    acc_a    <= '0;
                    acc_b    <= in_div ? rs_mag : rt_mag;
                    neg_res  <= rs_neg ^ rt_neg;
                    neg_rem  <= rs_neg;
                    div_zero <= in_div && (rt_val == '0);
                    div_ovf  <= (op_in == OP_DIV) && (rs_val == MOST_NEG) && (rt_val == '1);
                end
                RUN: begin
                    count <= count + 1'b1;
                    acc_a <= div_q ? div_a : mul_a;
                    acc_b <= div_q ? div_b : mul_b;
                end
                default: ;
            endcase
        end
    end

    // Sign correction and special-case results, consumed only in FIX.
    always_comb begin
        prod     = {acc_a, acc_b};
        prod_fix = neg_res ? -prod : prod;
        quot_fix = neg_res ? -acc_b : acc_b;
        rem_fix  = neg_rem ? -acc_a : acc_a;
        hi_res   = prod_fix[2*WORD_SIZE-1:WORD_SIZE];
        lo_res   = prod_fix[WORD_SIZE-1:0];
        if (div_q) begin
            if (div_zero) begin
                hi_res = rem_fix;
                lo_res = WORD_SIZE'(DIV0_QUOT);
            end else if (div_ovf) begin
                hi_res = WORD_SIZE'(OVF_REM);
                lo_res = WORD_SIZE'(ovf_quot(WORD_SIZE));
            end else begin
                hi_res = rem_fix;
                lo_res = quot_fix;
            end
        end
    end

    // A start in IDLE takes priority over a register move.
    assign fix     = (state == FIX);
    assign move_ok = (state == IDLE) && !start;
    assign hi_we   = fix || (move_ok && mthi);
    assign lo_we   = fix || (move_ok && mtlo);
    assign hi_d    = fix ? hi_res : rs_val;
    assign lo_d    = fix ? lo_res : rs_val;

    gen_register #(.WORD_SIZE(WORD_SIZE)) u_hi (
        .clk      (clk),
        .rst      (rst),
        .write_en (hi_we),
        .d        (hi_d),
        .q        (hi_out)
    );

    gen_register #(.WORD_SIZE(WORD_SIZE)) u_lo (
        .clk      (clk),
        .rst      (rst),
        .write_en (lo_we),
        .d        (lo_d),
        .q        (lo_out)
    );

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Bench for muldiv_ctrl: directed cases with literal results plus random ops,
// all checked each cycle against an arithmetic model of HI/LO/busy/done.
`timescale 1ns/1ps
module tb_muldiv_ctrl;

    localparam int W   = 32;
    localparam int LAT = W + 1;

    logic         clk = 1'b0, rst = 1'b0, start = 1'b0, mthi = 1'b0, mtlo = 1'b0;
    logic [1:0]   op = 2'b00;
    logic [W-1:0] rs_val = '0, rt_val = '0;
    logic         busy, done;
    logic [W-1:0] hi_out, lo_out;

    int total = 0, bad = 0;
    bit chk_en = 1'b0;

    logic [W-1:0] exp_hi = '0, exp_lo = '0, pend_hi = '0, pend_lo = '0;
    logic         exp_done = 1'b0;
    int           cyc_left = 0;

    muldiv_ctrl #(.WORD_SIZE(W), .CNT_W(6)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .rs_val (rs_val),
        .rt_val (rt_val),
        .mthi   (mthi),
        .mtlo   (mtlo),
        .busy   (busy),
        .done   (done),
        .hi_out (hi_out),
        .lo_out (lo_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural result of each operation, straight from the MIPS rules.
    function automatic void ref_model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                      output logic [W-1:0] hi, output logic [W-1:0] lo);
        logic [63:0] u;
        longint      sa, sb, sp, sq, sr;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            2'b00: begin u = {32'd0, a} * {32'd0, b}; hi = u[63:32]; lo = u[31:0]; end
            2'b01: begin sp = sa * sb; hi = sp[63:32]; lo = sp[31:0]; end
            2'b10: begin
                if (b == 0) begin hi = a; lo = '1; end
                else begin hi = a % b; lo = a / b; end
            end
            default: begin
                if (b == 0) begin hi = a; lo = '1; end
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin hi = '0; lo = 32'h8000_0000; end
                else begin sq = sa / sb; sr = sa % sb; hi = sr[31:0]; lo = sq[31:0]; end
            end
        endcase
    endfunction

    // Model: one result pending for LAT clocks after an accepted start.
    always @(posedge clk or posedge rst) begin : model
        logic [W-1:0] m_hi, m_lo;
        if (rst) begin
            exp_hi   <= '0;
            exp_lo   <= '0;
            exp_done <= 1'b0;
            cyc_left <= 0;
        end else begin
            exp_done <= 1'b0;
            if (cyc_left > 0) begin
                cyc_left <= cyc_left - 1;
                if (cyc_left == 1) begin
                    exp_hi   <= pend_hi;
                    exp_lo   <= pend_lo;
                    exp_done <= 1'b1;
                end
            end else if (start) begin
                ref_model(op, rs_val, rt_val, m_hi, m_lo);
                pend_hi  <= m_hi;
                pend_lo  <= m_lo;
                cyc_left <= LAT;
            end else begin
                if (mthi) exp_hi <= rs_val;
                if (mtlo) exp_lo <= rs_val;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en && !rst) begin
            check("cyc_busy", busy, cyc_left > 0);
            check("cyc_done", done, exp_done);
            check("cyc_hi", hi_out, exp_hi);
            check("cyc_lo", lo_out, exp_lo);
        end
    end

    // Issue one op; optionally pulse a stray start hit_at clocks into the run.
    task automatic run_op(input string name, input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] xh, input logic [W-1:0] xl, input bit mv, input int hit_at,
                          input logic [1:0] hop, input logic [W-1:0] ha, input logic [W-1:0] hb);
        int n, bc;
        @(negedge clk);
        start = 1'b1; op = o; rs_val = a; rt_val = b; mthi = mv; mtlo = mv;
        @(negedge clk);
        start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        n = 0;
        bc = 0;
        while (!done && n < LAT + 7) begin
            if (busy) bc++;
            @(negedge clk);
            n++;
            start = (n == hit_at);
            if (n == hit_at) begin op = hop; rs_val = ha; rt_val = hb; end
        end
        start = 1'b0;
        check({name, "_latency"}, n, LAT);
        check({name, "_busy_cycles"}, bc, LAT);
        check({name, "_hi"}, hi_out, xh);
        check({name, "_lo"}, lo_out, xl);
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return 32'd1;
            2:       return '1;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            5:       return W'($urandom_range(0, 20));
            6:       return W'(-int'($urandom_range(1, 20)));
            default: return $urandom();
        endcase
    endfunction

    initial begin : stim
        int dn;
        logic [W-1:0] xh, xl;
        logic [1:0]   o;
        logic [W-1:0] a, b;

        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_hi", hi_out, 0);
        check("rst_lo", lo_out, 0);
        rst = 1'b0;
        chk_en = 1'b1;

        run_op("multu_7x6", 2'b00, 32'd7, 32'd6, 32'h0, 32'h2A, 1'b0, -1, 2'b00, '0, '0);
        run_op("mult_m3x5", 2'b01, -32'sd3, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, -1, 2'b00, '0, '0);
        run_op("divu_100_7", 2'b10, 32'd100, 32'd7, 32'd2, 32'hE, 1'b0, -1, 2'b00, '0, '0);
        run_op("div_m7_2", 2'b11, -32'sd7, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, -1, 2'b00, '0, '0);
        run_op("div_ovf", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0, -1, 2'b00, '0, '0);
        run_op("divu_by0", 2'b10, 32'h1234_5678, 32'h0, 32'h1234_5678, 32'hFFFF_FFFF, 1'b0, -1, 2'b00, '0, '0);
        run_op("div_m9_by0", 2'b11, -32'sd9, 32'h0, 32'hFFFF_FFF7, 32'hFFFF_FFFF, 1'b0, -1, 2'b00, '0, '0);

        // Second start at E10 must be ignored and produce no extra done.
        run_op("multu_3x4_restart", 2'b00, 32'd3, 32'd4, 32'h0, 32'd12, 1'b0, 9, 2'b11, 32'd100, 32'd9);
        dn = 0;
        repeat (LAT + 7) begin
            @(negedge clk);
            if (done) dn++;
        end
        check("restart_no_second_done", dn, 0);

        // Reset mid-operation: outputs clear at once and nothing is written later.
        @(negedge clk);
        start = 1'b1; op = 2'b01; rs_val = 32'd5; rt_val = 32'd6;
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_hi", hi_out, 0);
        check("abort_lo", lo_out, 0);
        @(negedge clk);
        rst = 1'b0;
        dn = 0;
        repeat (LAT + 5) begin
            @(negedge clk);
            if (done) dn++;
        end
        check("abort_no_done", dn, 0);
        check("abort_lo_kept", lo_out, 0);

        // Register moves in IDLE.
        @(negedge clk);
        mthi = 1'b1; rs_val = 32'hDEAD_BEEF;
        @(negedge clk);
        mthi = 1'b0;
        check("mthi_hi", hi_out, 32'hDEAD_BEEF);
        check("mthi_lo", lo_out, 0);
        check("mthi_done", done, 0);
        mthi = 1'b1; mtlo = 1'b1; rs_val = 32'hCAFE_F00D;
        @(negedge clk);
        mthi = 1'b0; mtlo = 1'b0;
        check("mthilo_hi", hi_out, 32'hCAFE_F00D);
        check("mthilo_lo", lo_out, 32'hCAFE_F00D);

        // Start together with a move: the move is dropped.
        run_op("start_wins", 2'b00, 32'd2, 32'd3, 32'h0, 32'd6, 1'b1, -1, 2'b00, '0, '0);

        // Random traffic against the model.
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(negedge clk);
                mthi = 1'($urandom_range(0, 1));
                mtlo = 1'($urandom_range(0, 1));
                rs_val = $urandom();
                @(negedge clk);
                mthi = 1'b0; mtlo = 1'b0;
            end else begin
                o = 2'($urandom_range(0, 3));
                a = pick();
                b = pick();
                ref_model(o, a, b, xh, xl);
                run_op("rand", o, a, b, xh, xl, 1'($urandom_range(0, 1)),
                       ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 31)) : -1,
                       2'($urandom_range(0, 3)), $urandom(), $urandom());
            end
        end

        repeat (2) @(negedge clk);
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
